// File: rtl/wb_port_arbiter.sv
// ---------------------------------------------------------------------------
// wb_port_arbiter
// Two-master to one-slave Wishbone arbiter. It merges the instruction-fetch
// port (master I, read-only) and the data port (master D) onto one L2-side
// Wishbone bus. One master is granted per transaction. When both masters
// request in the same cycle, the grant alternates so that neither is starved.
// A completed-transaction counter is kept for each master.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   i_cyc/i_stb/i_adr            master I request
//   i_dat_s/i_ack                read data / ack returned to master I
//   d_cyc/d_stb/d_we/d_adr/
//   d_sel/d_dat_m                master D request
//   d_dat_s/d_ack                read data / ack returned to master D
//   l2_cyc/l2_stb/l2_we/l2_adr/
//   l2_sel/l2_dat_m              forwarded request to the slave
//   l2_dat_s/l2_ack              slave response
//   i_count/d_count              completed transactions per master (wrapping)
// ---------------------------------------------------------------------------
module wb_port_arbiter #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 128,
    parameter int SEL_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_cyc,
    input  logic              i_stb,
    input  logic [ADDR_W-1:0] i_adr,
    output logic [DATA_W-1:0] i_dat_s,
    output logic              i_ack,
    input  logic              d_cyc,
    input  logic              d_stb,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_adr,
    input  logic [SEL_W-1:0]  d_sel,
    input  logic [DATA_W-1:0] d_dat_m,
    output logic [DATA_W-1:0] d_dat_s,
    output logic              d_ack,
    output logic              l2_cyc,
    output logic              l2_stb,
    output logic              l2_we,
    output logic [ADDR_W-1:0] l2_adr,
    output logic [SEL_W-1:0]  l2_sel,
    output logic [DATA_W-1:0] l2_dat_m,
    input  logic [DATA_W-1:0] l2_dat_s,
    input  logic              l2_ack,
    output logic [15:0]       i_count,
    output logic [15:0]       d_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic        last_d_r;   // 1: D was granted most recently, 0: I was
    logic        last_d_s;
    logic        i_done_s;   // I transaction completes at the next edge
    logic        d_done_s;   // D transaction completes at the next edge
    logic [15:0] i_count_r;
    logic [15:0] d_count_r;
    logic        req_i_s;
    logic        req_d_s;

    assign req_i_s = i_cyc & i_stb;
    assign req_d_s = d_cyc & d_stb;
    assign i_count = i_count_r;
    assign d_count = d_count_r;

    // State, fairness pointer and completion counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            last_d_r  <= 1'b1;
            i_count_r <= 16'd0;
            d_count_r <= 16'd0;
        end else begin
            state_r  <= state_s;
            last_d_r <= last_d_s;
            if (i_done_s) begin
                i_count_r <= i_count_r + 16'd1;
            end else begin
                i_count_r <= i_count_r;
            end
            if (d_done_s) begin
                d_count_r <= d_count_r + 16'd1;
            end else begin
                d_count_r <= d_count_r;
            end
        end
    end

    // Next-state selection and combinational forwarding of the granted master.
    always_comb begin
        state_s  = state_r;
        last_d_s = last_d_r;
        i_done_s = 1'b0;
        d_done_s = 1'b0;
        l2_cyc   = 1'b0;
        l2_stb   = 1'b0;
        l2_we    = 1'b0;
        l2_adr   = {ADDR_W{1'b0}};
        l2_sel   = {SEL_W{1'b0}};
        l2_dat_m = {DATA_W{1'b0}};
        i_ack    = 1'b0;
        i_dat_s  = {DATA_W{1'b0}};
        d_ack    = 1'b0;
        d_dat_s  = {DATA_W{1'b0}};
        case (state_r)
            IDLE: begin
                // On contention, the master that did not win last time is granted.
                if (req_i_s && req_d_s) begin
                    if (last_d_r) begin
                        state_s  = GRANT_I;
                        last_d_s = 1'b0;
                    end else begin
                        state_s  = GRANT_D;
                        last_d_s = 1'b1;
                    end
                end else if (req_i_s) begin
                    state_s  = GRANT_I;
                    last_d_s = 1'b0;
                end else if (req_d_s) begin
                    state_s  = GRANT_D;
                    last_d_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            GRANT_I: begin
                // Instruction fetch never writes: full-line read.
                l2_cyc  = i_cyc;
                l2_stb  = i_stb;
                l2_we   = 1'b0;
                l2_adr  = i_adr;
                l2_sel  = {SEL_W{1'b1}};
                i_ack   = l2_ack;
                i_dat_s = l2_dat_s;
                // A dropped CYC aborts the transaction and takes precedence over a stray ack.
                if (!i_cyc) begin
                    state_s = IDLE;
                end else if (l2_ack) begin
                    state_s  = IDLE;
                    i_done_s = 1'b1;
                end else begin
                    state_s = GRANT_I;
                end
            end
            GRANT_D: begin
                l2_cyc   = d_cyc;
                l2_stb   = d_stb;
                l2_we    = d_we;
                l2_adr   = d_adr;
                l2_sel   = d_sel;
                l2_dat_m = d_dat_m;
                d_ack    = l2_ack;
                d_dat_s  = l2_dat_s;
                if (!d_cyc) begin
                    state_s = IDLE;
                end else if (l2_ack) begin
                    state_s  = IDLE;
                    d_done_s = 1'b1;
                end else begin
                    state_s = GRANT_D;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;
    localparam int ADDR_W = 12;
    localparam int DATA_W = 128;
    localparam int SEL_W  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_cyc, i_stb;
    logic [ADDR_W-1:0] i_adr;
    logic [DATA_W-1:0] i_dat_s;
    logic              i_ack;
    logic              d_cyc, d_stb, d_we;
    logic [ADDR_W-1:0] d_adr;
    logic [SEL_W-1:0]  d_sel;
    logic [DATA_W-1:0] d_dat_m;
    logic [DATA_W-1:0] d_dat_s;
    logic              d_ack;
    logic              l2_cyc, l2_stb, l2_we;
    logic [ADDR_W-1:0] l2_adr;
    logic [SEL_W-1:0]  l2_sel;
    logic [DATA_W-1:0] l2_dat_m;
    logic [DATA_W-1:0] l2_dat_s;
    logic              l2_ack;
    logic [15:0]       i_count, d_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: who owns the bus (0 none, 1 I, 2 D), who won last,
    // and how many transactions each master has completed.
    int m_owner = 0;
    int m_last  = 2;
    int m_ic    = 0;
    int m_dc    = 0;
    int dc_bias = 0;   // offset applied when the D counter is preloaded
    bit m_valid = 1'b0;

    logic [DATA_W-1:0] pat_a5 = {16{8'hA5}};
    logic [DATA_W-1:0] pat_wd = {4{32'hDEAD_BEEF}};

    wb_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SEL_W(SEL_W)) dut (
        .clk(clk), .rst(rst),
        .i_cyc(i_cyc), .i_stb(i_stb), .i_adr(i_adr), .i_dat_s(i_dat_s), .i_ack(i_ack),
        .d_cyc(d_cyc), .d_stb(d_stb), .d_we(d_we), .d_adr(d_adr), .d_sel(d_sel),
        .d_dat_m(d_dat_m), .d_dat_s(d_dat_s), .d_ack(d_ack),
        .l2_cyc(l2_cyc), .l2_stb(l2_stb), .l2_we(l2_we), .l2_adr(l2_adr),
        .l2_sel(l2_sel), .l2_dat_m(l2_dat_m), .l2_dat_s(l2_dat_s), .l2_ack(l2_ack),
        .i_count(i_count), .d_count(d_count)
    );

    always #5 clk = ~clk;

    // Model update on every rising edge.
    always @(posedge clk) begin
        if (rst) begin
            m_owner = 0;
            m_last  = 2;
            m_ic    = 0;
            m_dc    = 0;
            m_valid = 1'b1;
        end else if (m_owner == 0) begin
            if ((i_cyc && i_stb) && (d_cyc && d_stb))
                m_owner = (m_last == 2) ? 1 : 2;
            else if (i_cyc && i_stb)
                m_owner = 1;
            else if (d_cyc && d_stb)
                m_owner = 2;
            if (m_owner != 0)
                m_last = m_owner;
        end else if (m_owner == 1) begin
            if (!i_cyc) m_owner = 0;
            else if (l2_ack) begin m_ic = (m_ic + 1) % 65536; m_owner = 0; end
        end else begin
            if (!d_cyc) m_owner = 0;
            else if (l2_ack) begin m_dc = m_dc + 1; m_owner = 0; end
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic compare();
        logic              e_cyc, e_stb, e_we, e_iack, e_dack;
        logic [ADDR_W-1:0] e_adr;
        logic [SEL_W-1:0]  e_sel;
        logic [DATA_W-1:0] e_dm, e_ids, e_dds;
        logic [15:0]       e_dc;
        e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0; e_iack = 1'b0; e_dack = 1'b0;
        e_adr = '0; e_sel = '0; e_dm = '0; e_ids = '0; e_dds = '0;
        if (m_owner == 1) begin
            e_cyc = i_cyc; e_stb = i_stb; e_adr = i_adr; e_sel = 16'hFFFF;
            e_iack = l2_ack; e_ids = l2_dat_s;
        end else if (m_owner == 2) begin
            e_cyc = d_cyc; e_stb = d_stb; e_we = d_we; e_adr = d_adr; e_sel = d_sel;
            e_dm = d_dat_m; e_dack = l2_ack; e_dds = l2_dat_s;
        end
        e_dc = 16'((m_dc + dc_bias) % 65536);
        chk("m_l2_cyc", l2_cyc, e_cyc);
        chk("m_l2_stb", l2_stb, e_stb);
        chk("m_l2_we", l2_we, e_we);
        chk("m_l2_adr", l2_adr, e_adr);
        chk("m_l2_sel", l2_sel, e_sel);
        chk("m_l2_dat_m", l2_dat_m, e_dm);
        chk("m_i_ack", i_ack, e_iack);
        chk("m_d_ack", d_ack, e_dack);
        chk("m_i_dat_s", i_dat_s, e_ids);
        chk("m_d_dat_s", d_dat_s, e_dds);
        chk("m_i_count", i_count, 16'(m_ic));
        chk("m_d_count", d_count, e_dc);
        chk("m_dual_ack", i_ack & d_ack, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        i_cyc = 1'b0; i_stb = 1'b0; i_adr = '0;
        d_cyc = 1'b0; d_stb = 1'b0; d_we = 1'b0; d_adr = '0; d_sel = '0; d_dat_m = '0;
        l2_dat_s = '0; l2_ack = 1'b0;
        fork
            forever begin
                @(negedge clk);
                if (m_valid) compare();
            end
        join_none

        tick(); tick(); rst = 1'b0;
        at_neg();
        chk("rst_l2_cyc", l2_cyc, 1'b0);
        chk("rst_i_count", i_count, 16'd0);
        chk("rst_d_count", d_count, 16'd0);

        // Lone I read
        tick(); i_cyc = 1'b1; i_stb = 1'b1; i_adr = 12'h123;
        at_neg(); chk("i_stb_not_yet", l2_stb, 1'b0);
        tick(); at_neg();
        chk("i_l2_stb", l2_stb, 1'b1);
        chk("i_l2_adr", l2_adr, 12'h123);
        chk("i_l2_we", l2_we, 1'b0);
        chk("i_l2_sel", l2_sel, 16'hFFFF);
        tick(); l2_ack = 1'b1; l2_dat_s = pat_a5;
        at_neg();
        chk("i_ack", i_ack, 1'b1);
        chk("i_dat_s", i_dat_s, pat_a5);
        chk("i_d_ack_quiet", d_ack, 1'b0);
        tick(); l2_ack = 1'b0; l2_dat_s = '0; i_cyc = 1'b0; i_stb = 1'b0;
        at_neg();
        chk("i_count_1", i_count, 16'd1);
        chk("i_idle_cyc", l2_cyc, 1'b0);

        // Lone D write
        tick(); d_cyc = 1'b1; d_stb = 1'b1; d_we = 1'b1; d_sel = 16'h0030;
        d_adr = 12'h0FF; d_dat_m = pat_wd;
        tick(); at_neg();
        chk("d_l2_we", l2_we, 1'b1);
        chk("d_l2_sel", l2_sel, 16'h0030);
        chk("d_l2_adr", l2_adr, 12'h0FF);
        chk("d_l2_dat_m", l2_dat_m, pat_wd);
        tick(); l2_ack = 1'b1;
        at_neg();
        chk("d_ack", d_ack, 1'b1);
        chk("d_i_ack_quiet", i_ack, 1'b0);
        tick(); l2_ack = 1'b0; d_cyc = 1'b0; d_stb = 1'b0; d_we = 1'b0;
        at_neg();
        chk("d_count_1", d_count, 16'd1);
        chk("d_i_count_kept", i_count, 16'd1);

        // Simultaneous requests after reset: I, D, I, D
        tick(); rst = 1'b1;
        tick(); rst = 1'b0;
        tick(); i_cyc = 1'b1; i_stb = 1'b1; i_adr = 12'h200;
        d_cyc = 1'b1; d_stb = 1'b1; d_we = 1'b0; d_adr = 12'h300; d_sel = 16'hFFFF;
        for (int k = 0; k < 4; k++) begin
            tick(); l2_ack = 1'b1;
            at_neg();
            chk("order_acks", {i_ack, d_ack}, (k % 2 == 0) ? 2'b10 : 2'b01);
            chk("order_adr", l2_adr, (k % 2 == 0) ? 12'h200 : 12'h300);
            tick(); l2_ack = 1'b0;
            if (k == 3) begin
                i_cyc = 1'b0; i_stb = 1'b0; d_cyc = 1'b0; d_stb = 1'b0;
            end
        end
        at_neg();
        chk("order_i_count", i_count, 16'd2);
        chk("order_d_count", d_count, 16'd2);

        // Abort of a D transaction
        tick(); d_cyc = 1'b1; d_stb = 1'b1; d_we = 1'b1; d_adr = 12'h0AB; d_sel = 16'h000F;
        tick(); at_neg(); chk("abort_granted", l2_cyc, 1'b1);
        tick(); d_cyc = 1'b0;
        at_neg();
        chk("abort_l2_cyc", l2_cyc, 1'b0);
        chk("abort_d_ack", d_ack, 1'b0);
        tick(); d_stb = 1'b0; d_we = 1'b0;
        at_neg();
        chk("abort_d_count", d_count, 16'd2);
        chk("abort_idle_stb", l2_stb, 1'b0);

        // Reset during GRANT_I
        tick(); i_cyc = 1'b1; i_stb = 1'b1; i_adr = 12'h055;
        tick(); at_neg(); chk("rstmid_granted", l2_cyc, 1'b1);
        tick(); rst = 1'b1;
        tick(); rst = 1'b0; i_cyc = 1'b0; i_stb = 1'b0;
        at_neg();
        chk("rstmid_l2_cyc", l2_cyc, 1'b0);
        chk("rstmid_l2_adr", l2_adr, 12'h000);
        chk("rstmid_i_count", i_count, 16'd0);
        chk("rstmid_d_count", d_count, 16'd0);

        // Stray ack in IDLE
        tick(); l2_ack = 1'b1; l2_dat_s = pat_a5;
        at_neg();
        chk("stray_i_ack", i_ack, 1'b0);
        chk("stray_d_ack", d_ack, 1'b0);
        chk("stray_i_dat", i_dat_s, 128'h0);
        tick(); l2_ack = 1'b0; l2_dat_s = '0;
        at_neg();
        chk("stray_i_count", i_count, 16'd0);
        chk("stray_d_count", d_count, 16'd0);

        // Counter wrap: preload D count to its maximum, then one more transaction
        tick();
        force dut.d_count_r = 16'hFFFF;
        release dut.d_count_r;
        dc_bias = 65535;
        at_neg(); chk("wrap_preload", d_count, 16'hFFFF);
        tick(); d_cyc = 1'b1; d_stb = 1'b1; d_adr = 12'h010; d_sel = 16'h0001;
        tick(); l2_ack = 1'b1;
        at_neg(); chk("wrap_d_ack", d_ack, 1'b1);
        tick(); l2_ack = 1'b0; d_cyc = 1'b0; d_stb = 1'b0;
        at_neg();
        chk("wrap_d_count", d_count, 16'd0);
        chk("wrap_i_count", i_count, 16'd0);

        tick();
        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
